axi_ar_outstanding_err_resp: RTL and testbench

//  Companion of the per-target-port AR address decoder in the AXI node.
//  - Tracks outstanding routed read bursts; drives full/outstanding flags back to the decoder.
//  - When the decoder accepts an unmapped AR, waits until all older routed reads drain.
//  - Then emits ARLEN+1 DECERR R beats on a private R port toward the R allocator.
//  - Finally pulses error_gnt_o so the decoder leaves its ERROR state.

---
 rtl/axi_ar_outstanding_err_resp.sv | 166 ++++++++++++++++
 tb/tb_axi_ar_outstanding_err_resp.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/axi_ar_outstanding_err_resp.sv
// Outstanding routed-read tracker and DECERR read responder for one AR decoder port.
// Unmapped reads wait for older routed bursts to drain, then return ARLEN+1 DECERR beats.

module axi_ar_outstanding_err_resp_chk (
  input logic clk,
  input logic rst_n,
  input logic incr_req_i,
  input logic r_done_i,
  input logic sample_ardata_info_i,
  input logic full_s,
  input logic empty_s,
  input logic idle_s,
  input logic wait_or_resp_s
);

  a_incr_at_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(incr_req_i && !r_done_i && full_s));

  a_done_at_zero: assert property (@(posedge clk) disable iff (!rst_n)
    !(r_done_i && !incr_req_i && empty_s));

  a_sample_not_idle: assert property (@(posedge clk) disable iff (!rst_n)
    !(sample_ardata_info_i && !idle_s));

  a_incr_while_err: assert property (@(posedge clk) disable iff (!rst_n)
    !(incr_req_i && wait_or_resp_s));

endmodule

module axi_ar_outstanding_err_resp #(
  parameter int AXI_ID_W   = 16,
  parameter int AXI_USER_W = 6,
  parameter int AXI_DATA_W = 64,
  parameter int MAX_OUTSTD = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  incr_req_i,
  input  logic                  r_done_i,
  output logic                  full_counter_o,
  output logic                  outstanding_trans_o,
  input  logic                  sample_ardata_info_i,
  input  logic [AXI_ID_W-1:0]   arid_i,
  input  logic [7:0]            arlen_i,
  input  logic [AXI_USER_W-1:0] aruser_i,
  output logic                  error_gnt_o,
  output logic                  rvalid_o,
  input  logic                  rready_i,
  output logic [AXI_ID_W-1:0]   rid_o,
  output logic [AXI_DATA_W-1:0] rdata_o,
  output logic [1:0]            rresp_o,
  output logic                  rlast_o,
  output logic [AXI_USER_W-1:0] ruser_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTD + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    RESP  = 2'd2,
    GNT   = 2'd3
  } state_e;

  state_e                state_r;
  state_e                state_s;
  logic [CNT_W-1:0]      count_r;
  logic [7:0]            beat_r;
  logic [7:0]            len_r;
  logic [AXI_ID_W-1:0]   id_r;
  logic [AXI_USER_W-1:0] user_r;
  logic                  full_s;
  logic                  empty_s;
  logic                  last_s;
  logic                  hs_s;

  assign full_s  = (count_r == CNT_W'(MAX_OUTSTD));
  assign empty_s = (count_r == {CNT_W{1'b0}});
  assign last_s  = (beat_r == len_r);
  assign hs_s    = (state_r == RESP) && rready_i;

  // Outstanding routed burst counter; saturates at both ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CNT_W{1'b0}};
    end else begin
      case ({incr_req_i, r_done_i})
        2'b10:   count_r <= full_s  ? count_r : count_r + CNT_W'(1);
        2'b01:   count_r <= empty_s ? count_r : count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic; DRAIN exit uses the registered count.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (sample_ardata_info_i) state_s = DRAIN;
        else                      state_s = IDLE;
      end
      DRAIN: begin
        if (empty_s) state_s = RESP;
        else         state_s = DRAIN;
      end
      RESP: begin
        if (rready_i && last_s) state_s = GNT;
        else                    state_s = RESP;
      end
      GNT:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Captured AR attributes and beat counter for the error burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_r <= 8'd0;
      len_r  <= 8'd0;
      id_r   <= {AXI_ID_W{1'b0}};
      user_r <= {AXI_USER_W{1'b0}};
    end else if (state_r == IDLE && sample_ardata_info_i) begin
      beat_r <= 8'd0;
      len_r  <= arlen_i;
      id_r   <= arid_i;
      user_r <= aruser_i;
    end else if (hs_s && !last_s) begin
      beat_r <= beat_r + 8'd1;
    end else begin
      beat_r <= beat_r;
    end
  end

  assign full_counter_o      = full_s;
  assign outstanding_trans_o = !empty_s;
  assign error_gnt_o         = (state_r == GNT);
  assign rvalid_o            = (state_r == RESP);
  assign rlast_o             = (state_r == RESP) && last_s;
  assign rresp_o             = (state_r == RESP) ? 2'b11 : 2'b00;
  assign rid_o               = id_r;
  assign ruser_o             = user_r;
  assign rdata_o             = {AXI_DATA_W{1'b0}};

  axi_ar_outstanding_err_resp_chk u_chk (
    .clk                  (clk),
    .rst_n                (rst_n),
    .incr_req_i           (incr_req_i),
    .r_done_i             (r_done_i),
    .sample_ardata_info_i (sample_ardata_info_i),
    .full_s               (full_s),
    .empty_s              (empty_s),
    .idle_s               (state_r == IDLE),
    .wait_or_resp_s       ((state_r == DRAIN) || (state_r == RESP))
  );

endmodule

// File: tb/tb_axi_ar_outstanding_err_resp.sv
// Directed self-checking bench for axi_ar_outstanding_err_resp.
module tb_axi_ar_outstanding_err_resp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        incr_req_i, r_done_i, sample_ardata_info_i, rready_i;
  logic [15:0] arid_i;
  logic [7:0]  arlen_i;
  logic [5:0]  aruser_i;
  logic        full_counter_o, outstanding_trans_o, error_gnt_o, rvalid_o, rlast_o;
  logic [15:0] rid_o;
  logic [63:0] rdata_o;
  logic [1:0]  rresp_o;
  logic [5:0]  ruser_o;

  int checks = 0;
  int failures = 0;
  int acc;
  int cyc;

  axi_ar_outstanding_err_resp #(
    .AXI_ID_W(16), .AXI_USER_W(6), .AXI_DATA_W(64), .MAX_OUTSTD(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .incr_req_i(incr_req_i), .r_done_i(r_done_i),
    .full_counter_o(full_counter_o), .outstanding_trans_o(outstanding_trans_o),
    .sample_ardata_info_i(sample_ardata_info_i),
    .arid_i(arid_i), .arlen_i(arlen_i), .aruser_i(aruser_i),
    .error_gnt_o(error_gnt_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
    .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o),
    .rlast_o(rlast_o), .ruser_o(ruser_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sample(input logic [15:0] id, input logic [7:0] len, input logic [5:0] user);
    sample_ardata_info_i = 1'b1;
    arid_i = id; arlen_i = len; aruser_i = user;
    tick();
    sample_ardata_info_i = 1'b0;
    arid_i = 16'h0; arlen_i = 8'h0; aruser_i = 6'h0;
  endtask

  task automatic burst4(input logic [15:0] id, input string tag);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_rvalid"}, rvalid_o, 1'b1);
      chk({tag, "_rresp"}, rresp_o, 2'b11);
      chk({tag, "_rid"}, rid_o, id);
      chk({tag, "_rlast"}, rlast_o, (i == 3) ? 1'b1 : 1'b0);
      chk({tag, "_gnt_early"}, error_gnt_o, 1'b0);
      tick();
    end
    chk({tag, "_gnt"}, error_gnt_o, 1'b1);
    chk({tag, "_rvalid_off"}, rvalid_o, 1'b0);
    tick();
    chk({tag, "_gnt_once"}, error_gnt_o, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    incr_req_i = 1'b0; r_done_i = 1'b0; sample_ardata_info_i = 1'b0; rready_i = 1'b0;
    arid_i = 16'h0; arlen_i = 8'h0; aruser_i = 6'h0;

    // 1: reset with incr pulses in flight
    incr_req_i = 1'b1;
    tick(); tick();
    chk("rst_outstd", outstanding_trans_o, 1'b0);
    chk("rst_full", full_counter_o, 1'b0);
    chk("rst_rvalid", rvalid_o, 1'b0);
    chk("rst_gnt", error_gnt_o, 1'b0);
    chk("rst_rresp", rresp_o, 2'b00);
    chk("rst_rid", rid_o, 16'h0);
    incr_req_i = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("post_rst_outstd", outstanding_trans_o, 1'b0);

    // 2: fill to 8, simultaneous incr/done, drain
    incr_req_i = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    chk("cnt7_full", full_counter_o, 1'b0);
    chk("cnt7_outstd", outstanding_trans_o, 1'b1);
    tick();
    chk("cnt8_full", full_counter_o, 1'b1);
    r_done_i = 1'b1;
    tick();
    chk("both_full", full_counter_o, 1'b1);
    incr_req_i = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("cnt1_outstd", outstanding_trans_o, 1'b1);
    chk("cnt1_full", full_counter_o, 1'b0);
    tick();
    r_done_i = 1'b0;
    chk("cnt0_outstd", outstanding_trans_o, 1'b0);

    // 3: count 0, arlen 3, rready high
    rready_i = 1'b1;
    sample(16'h005A, 8'd3, 6'h15);
    chk("t3_drain_rvalid", rvalid_o, 1'b0);
    tick();
    chk("t3_ruser", ruser_o, 6'h15);
    chk("t3_rdata", rdata_o, 64'h0);
    burst4(16'h005A, "t3");

    // 4: count 2 at sample, single-beat response after drain
    incr_req_i = 1'b1;
    tick(); tick();
    incr_req_i = 1'b0;
    sample(16'h00C3, 8'd0, 6'h01);
    tick();
    chk("t4_wait0", rvalid_o, 1'b0);
    r_done_i = 1'b1;
    tick();
    chk("t4_wait1", rvalid_o, 1'b0);
    tick();
    r_done_i = 1'b0;
    chk("t4_wait2", rvalid_o, 1'b0);
    chk("t4_cnt0", outstanding_trans_o, 1'b0);
    tick();
    chk("t4_rvalid", rvalid_o, 1'b1);
    chk("t4_rlast", rlast_o, 1'b1);
    chk("t4_rid", rid_o, 16'h00C3);
    tick();
    chk("t4_gnt", error_gnt_o, 1'b1);
    tick();
    chk("t4_gnt_once", error_gnt_o, 1'b0);

    // 5: arlen 7 with rready toggling
    rready_i = 1'b0;
    sample(16'h1234, 8'd7, 6'h2A);
    tick();
    acc = 0;
    cyc = 0;
    while (!error_gnt_o && cyc < 40) begin
      rready_i = (cyc % 2 == 0) ? 1'b1 : 1'b0;
      chk("t5_rvalid", rvalid_o, 1'b1);
      chk("t5_rid", rid_o, 16'h1234);
      chk("t5_ruser", ruser_o, 6'h2A);
      chk("t5_rlast", rlast_o, (acc == 7) ? 1'b1 : 1'b0);
      if (rvalid_o && rready_i) acc++;
      tick();
      cyc++;
    end
    chk("t5_gnt_in_time", error_gnt_o, 1'b1);
    chk("t5_beats", acc, 8);
    chk("t5_rvalid_off", rvalid_o, 1'b0);
    tick();
    chk("t5_gnt_once", error_gnt_o, 1'b0);

    // 6: reset mid-burst, then a fresh burst
    rready_i = 1'b1;
    sample(16'h0099, 8'd3, 6'h07);
    tick();
    tick(); tick();
    chk("t6_mid_rvalid", rvalid_o, 1'b1);
    chk("t6_mid_rlast", rlast_o, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_rvalid", rvalid_o, 1'b0);
    chk("t6_rst_rresp", rresp_o, 2'b00);
    chk("t6_rst_rid", rid_o, 16'h0);
    tick();
    chk("t6_rst_gnt", error_gnt_o, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("t6_idle_gnt", error_gnt_o, 1'b0);
    chk("t6_idle_rvalid", rvalid_o, 1'b0);
    sample(16'h0077, 8'd3, 6'h3F);
    tick();
    burst4(16'h0077, "t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
